// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with per-frame input snapshot,
// hex decode, leading-zero blanking and per-digit blink.
module seven_seg_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] display,
    input  logic        blank_lz,
    input  logic [3:0]  blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX    = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] prescale;
    logic [1:0]    index;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [15:0]   shadow_display;
    logic          shadow_blank_lz;
    logic [3:0]    shadow_blink_en;

    logic          tick;
    logic          frame_start;
    logic [3:0]    nibble;
    logic [3:0]    lz_mask;
    logic          blanked;
    logic [3:0]    next_an;
    logic [6:0]    next_seg;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    assign tick        = (prescale == PRESCALE_MAX);
    assign frame_start = tick && (index == 2'd3);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        nibble     = shadow_display[{index, 2'b00} +: 4];
        // lz_mask[k]: nibbles k..3 of the snapshot are all zero
        lz_mask    = 4'b0000;
        lz_mask[3] = (shadow_display[15:12] == 4'h0);
        lz_mask[2] = lz_mask[3] && (shadow_display[11:8] == 4'h0);
        lz_mask[1] = lz_mask[2] && (shadow_display[7:4] == 4'h0);
        blanked    = (shadow_blank_lz && lz_mask[index])
                   || (blink_phase && shadow_blink_en[index]);
        next_an    = 4'b1111;
        next_seg   = 7'b1111111;
        if (!blanked) begin
            next_an  = ~(4'b0001 << index);
            next_seg = hex_to_seg(nibble);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            prescale        <= '0;
            index           <= 2'd3;
            frame_cnt       <= '0;
            blink_phase     <= 1'b0;
            shadow_display  <= '0;
            shadow_blank_lz <= 1'b0;
            shadow_blink_en <= '0;
            frame_done      <= 1'b0;
            an              <= 4'b1111;
            seg             <= 7'b1111111;
        end else begin
            prescale   <= tick ? '0 : prescale + 1'b1;
            frame_done <= frame_start;
            an         <= next_an;
            seg        <= next_seg;
            if (tick) begin
                index <= index + 2'd1;
            end
            if (frame_start) begin
                shadow_display  <= display;
                shadow_blank_lz <= blank_lz;
                shadow_blink_en <= blink_en;
                if (frame_cnt == FRAME_MAX) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV=4, BLINK_FRAMES=2;
// expected anode/segment patterns are hand-computed per frame.
module tb_seven_seg_scan;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] display = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_en = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;

    seven_seg_scan #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .display    (display),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One digit slot: four output cycles; frame_done rises on the last cycle of digit 3.
    task automatic slot(input int k, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("an d%0d c%0d", k, c), 16'(an), 16'(exp_an));
            check($sformatf("seg d%0d c%0d", k, c), 16'(seg), 16'(exp_seg));
            check($sformatf("frame_done d%0d c%0d", k, c), 16'(frame_done), 16'((k == 3) && (c == 3)));
        end
    endtask

    // segs packs digit k at [7k+:7], ans packs digit k at [4k+:4].
    task automatic frame(input logic [15:0] ans, input logic [27:0] segs);
        for (int k = 0; k < 4; k++) begin
            slot(k, ans[4*k +: 4], segs[7*k +: 7]);
        end
    endtask

    localparam logic [15:0] ALL_LIT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    initial begin
        // Reset held for three edges
        display = 16'h12AF;
        repeat (3) step();
        check("reset an", 16'(an), 16'hF);
        check("reset seg", 16'(seg), 16'(SB));
        check("reset frame_done", 16'(frame_done), 16'h0);

        // First frame start on the 4th edge after release
        RST = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("first frame_done e%0d", c), 16'(frame_done), 16'(c == 4));
        end

        // Frame 1: 12AF scanned right to left
        frame(ALL_LIT, {S1, S2, SA, SF});

        // Frame 2: display changes mid-frame, no tearing
        slot(0, 4'b1110, SF);
        slot(1, 4'b1101, SA);
        display = 16'h0000;
        slot(2, 4'b1011, S2);
        slot(3, 4'b0111, S1);

        // Frame 3: zeros; new blank_lz/display must not apply until next frame
        blank_lz = 1'b1;
        display  = 16'h0030;
        frame(ALL_LIT, {S0, S0, S0, S0});

        // Frame 4: leading-zero blanking of 0030
        display = 16'h0000;
        frame({4'b1111, 4'b1111, 4'b1101, 4'b1110}, {SB, SB, S3, S0});

        // Frame 5: 0000 with blanking keeps digit 0
        blank_lz = 1'b0;
        display  = 16'h8888;
        blink_en = 4'b0001;
        frame({4'b1111, 4'b1111, 4'b1111, 4'b1110}, {SB, SB, SB, S0});

        // Frames 6..10: blink of digit 0, two frames off, two on, off again
        frame({4'b0111, 4'b1011, 4'b1101, 4'b1111}, {S8, S8, S8, SB});
        frame({4'b0111, 4'b1011, 4'b1101, 4'b1111}, {S8, S8, S8, SB});
        frame(ALL_LIT, {S8, S8, S8, S8});
        frame(ALL_LIT, {S8, S8, S8, S8});
        frame({4'b0111, 4'b1011, 4'b1101, 4'b1111}, {S8, S8, S8, SB});

        // Frame 11: reset while digit 2 is shown
        slot(0, 4'b1111, SB);
        slot(1, 4'b1101, S8);
        step();
        check("pre-reset an", 16'(an), 16'(4'b1011));
        RST = 1'b0;
        step();
        check("mid reset an", 16'(an), 16'hF);
        check("mid reset seg", 16'(seg), 16'(SB));
        check("mid reset frame_done", 16'(frame_done), 16'h0);
        RST = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("restart frame_done e%0d", c), 16'(frame_done), 16'(c == 4));
        end
        // Blink phase restarts at 0, so digit 0 is lit again
        step();
        check("restart an", 16'(an), 16'(4'b1110));
        check("restart seg", 16'(seg), 16'(S8));
        check("restart frame_done low", 16'(frame_done), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
